lif_chain: RTL
==============

# lif_chain

Parametrised chain of leaky integrate-and-fire (LIF) neuron stages. It is the next generation of the fixed 8-stage, 8-bit neuron cascade driven from `ui_in`, and adds configurable depth and width, a shift-based leak, threshold firing with refractory hold-off, and a selectable inter-stage coupling mode. It also provides per-stage spike outputs and a saturating spike counter on the last stage. It sits between the input switches and the display and GPIO outputs of the tile.

## Interface
- `N_STAGES`, default 8: number of cascaded neuron stages (≥1).
- `WIDTH`, default 8: membrane, input, threshold and weight width.
- `REFR_W`, default 4: refractory counter width.
- `COUNT_W`, default 16: spike counter width.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-high reset (1 = reset).
- `en`  in  1: advance all stages when 1; hold all state when 0.
- `i_syn`  in  WIDTH: synaptic input current to stage 0.
- `threshold`  in  WIDTH: firing threshold; 0 disables firing.
- `leak_shift`  in  3: leak term is `v >> leak_shift`; 0 means no leak.
- `refr_cycles`  in  REFR_W: cycles a stage is held at 0 after a spike.
- `weight`  in  WIDTH: current injected into stage k+1 when stage k spikes (mode 1).
- `mode`  in  1: 0 = next stage input is the previous stage's `v`; 1 = next stage input is `spike ? weight : 0`.
- `clr_count`  in  1: synchronous clear of `spike_count`.
- `v_mem_out`  out  WIDTH: membrane of the last stage.
- `spikes`  out  N_STAGES: registered spike flag of each stage; bit k is stage k.
- `spike_count`  out  COUNT_W: number of last-stage spikes.

## Operation
- Each stage holds three registers: `v` (WIDTH bits), `spike` (1 bit) and `refr` (REFR_W bits).
- Stage input `in_k`:
  - Stage 0 takes `i_syn`.
  - Stage k>0 takes the registered `v` or `spike` of stage k-1, selected by `mode`.
- Each rising edge with `en`=1, per stage:
  - If `refr`≠0: `refr`←`refr`-1, `v`←0, `spike`←0.
  - Otherwise compute `sum = v - leak + in_k` in WIDTH+1 bits. `leak` = 0 when `leak_shift`=0, else `v>>leak_shift`. Saturate `sum` to 2^WIDTH-1.
  - If `threshold`≠0 and `sum`≥`threshold`: `spike`←1, `v`←0, `refr`←`refr_cycles`.
  - Else: `v`←`sum`, `spike`←0.
- `en`=0: `v`, `refr` and `spike_count` hold; all `spike` registers clear to 0. Spikes are therefore single-cycle pulses.
- `spike_count`:
  - Increments on each edge where the new `spikes[N_STAGES-1]` is 1.
  - Saturates at 2^COUNT_W-1.
  - `clr_count` has priority over an increment in the same cycle; the result is 0.
- `threshold`, `leak_shift`, `refr_cycles`, `weight` and `mode` are sampled every edge. Changes take effect on the next edge, and no stage state is flushed.
- `refr_cycles`=0: no hold-off; the stage integrates again on the very next edge.

## Timing
- Reset (asynchronous, any time, including mid-refractory): all `v`, `refr`, `spikes`, `v_mem_out` and `spike_count` go to 0 immediately. They stay 0 while `rst_n`=1. Normal operation resumes on the first edge after deassertion.
- Latency: 1 cycle per stage. A change on `i_syn` affects stage 0 `v` at edge +1 and stage k at edge +(k+1).
- Mode 1: a spike of stage k registered at edge t adds `weight` into stage k+1 at edge t+1.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `lif_pkg` contains:
  - default parameter constants;
  - a saturating-add function;
  - the leak function (`v>>s`, or 0 when s=0);
  - the mode encoding constants `MODE_VMEM`=0 and `MODE_SPIKE`=1.
- Sub-module `lif_stage` holds one neuron (`v`, `spike`, `refr`). The top generates `N_STAGES` instances, the coupling muxes and the counter.

## Test plan
- Reset: drive `rst_n`=1 mid-run with stages spiking → all outputs 0 in the same cycle. After release, `v_mem_out` and `spike_count` start from 0.
- Mode 1 propagation (N=8, W=8): `threshold`=100, `leak_shift`=0, `refr_cycles`=0, `weight`=100, `i_syn`=50 → stage 0 `v`=50 at edge 1 and spikes at edge 2. Stage k first spikes at edge 2+k. `spikes[7]` first pulses at edge 9 and `spike_count`=1.
- Leak: `leak_shift`=1, `threshold`=255, `i_syn`=10 → stage 0 `v` = 10, 18, 19, 20, 20 … at edges 1, 3, 4, 5, 6. Steady state is 20 with no spikes.
- Saturation: `mode`=0, `threshold`=0, `leak_shift`=0, `i_syn`=200 → stage 0 `v`=200 then 255 and holds. `spikes` stays 0.
- Refractory: `threshold`=100, `i_syn`=100, `refr_cycles`=3 → `spikes[0]` pulses at edges 1, 5, 9 (period 4). `v`=0 on the hold edges.
- Counter edge cases: assert `clr_count` on the same edge as a last-stage spike → `spike_count`=0. With `COUNT_W`=2 and 5 spikes → `spike_count` holds at 3. `en`=0 for 3 cycles → `v` and the count are frozen and `spikes`=0.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and arithmetic helpers for the LIF neuron chain.
package lif_pkg;

    localparam int unsigned DEF_N_STAGES = 8;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_REFR_W   = 4;
    localparam int unsigned DEF_COUNT_W  = 16;
    localparam int unsigned LEAK_SHIFT_W = 3;

    // Helpers work on a common wide word; callers cast back to their width (<= MAX_W).
    localparam int unsigned MAX_W = 32;

    localparam logic MODE_VMEM  = 1'b0;
    localparam logic MODE_SPIKE = 1'b1;

    // Add two w-bit unsigned values, clamping the result to 2^w-1.
    function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int unsigned      w);
        logic [MAX_W:0] s;
        logic [MAX_W:0] lim;
        s   = {1'b0, a} + {1'b0, b};
        lim = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
        return (s > lim) ? lim[MAX_W-1:0] : s[MAX_W-1:0];
    endfunction

    // Shift-based leak term; a zero shift disables the leak entirely.
    function automatic logic [MAX_W-1:0] lif_leak(input logic [MAX_W-1:0]        v,
                                                  input logic [LEAK_SHIFT_W-1:0] s);
        return (s == '0) ? '0 : (v >> s);
    endfunction

endpackage

// File: rtl/lif_chain_if.sv
// Configuration, stimulus and observation bundle of the LIF chain.
interface lif_chain_if #(
    parameter int unsigned N_STAGES = lif_pkg::DEF_N_STAGES,
    parameter int unsigned WIDTH    = lif_pkg::DEF_WIDTH,
    parameter int unsigned REFR_W   = lif_pkg::DEF_REFR_W,
    parameter int unsigned COUNT_W  = lif_pkg::DEF_COUNT_W
) ();

    logic                            en;
    logic [WIDTH-1:0]                i_syn;
    logic [WIDTH-1:0]                threshold;
    logic [lif_pkg::LEAK_SHIFT_W-1:0] leak_shift;
    logic [REFR_W-1:0]               refr_cycles;
    logic [WIDTH-1:0]                weight;
    logic                            mode;
    logic                            clr_count;
    logic [WIDTH-1:0]                v_mem_out;
    logic [N_STAGES-1:0]             spikes;
    logic [COUNT_W-1:0]              spike_count;

    modport master (
        output en, i_syn, threshold, leak_shift, refr_cycles, weight, mode, clr_count,
        input  v_mem_out, spikes, spike_count
    );

    modport slave (
        input  en, i_syn, threshold, leak_shift, refr_cycles, weight, mode, clr_count,
        output v_mem_out, spikes, spike_count
    );

endinterface

// File: rtl/lif_stage.sv
// One leaky integrate-and-fire neuron: membrane, spike flag and refractory counter.
module lif_stage
    import lif_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned REFR_W = DEF_REFR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [WIDTH-1:0]        in_val,
    input  logic [WIDTH-1:0]        threshold,
    input  logic [LEAK_SHIFT_W-1:0] leak_shift,
    input  logic [REFR_W-1:0]       refr_cycles,
    output logic [WIDTH-1:0]        v,
    output logic                    spike,
    output logic                    spike_c
);

    logic [REFR_W-1:0] refr;
    logic [REFR_W-1:0] refr_nxt;
    logic [WIDTH-1:0]  v_nxt;
    logic [WIDTH-1:0]  sum;

    // Next-state: refractory hold, otherwise leak/integrate/fire.
    always_comb begin
        v_nxt    = v;
        refr_nxt = refr;
        spike_c  = 1'b0;
        sum      = WIDTH'(sat_add(MAX_W'(v) - lif_leak(MAX_W'(v), leak_shift),
                                  MAX_W'(in_val), WIDTH));
        if (refr != '0) begin
            refr_nxt = refr - REFR_W'(1);
            v_nxt    = '0;
        end else if ((threshold != '0) && (sum >= threshold)) begin
            spike_c  = 1'b1;
            v_nxt    = '0;
            refr_nxt = refr_cycles;
        end else begin
            v_nxt    = sum;
        end
    end

    // Disabled cycles freeze the neuron but still drop the spike pulse.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v     <= '0;
            refr  <= '0;
            spike <= 1'b0;
        end else if (en) begin
            v     <= v_nxt;
            refr  <= refr_nxt;
            spike <= spike_c;
        end else begin
            spike <= 1'b0;
        end
    end

endmodule

// File: rtl/lif_chain.sv
// Cascade of LIF neurons with selectable coupling and a last-stage spike counter.
module lif_chain
    import lif_pkg::*;
#(
    parameter int unsigned N_STAGES = DEF_N_STAGES,
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned REFR_W   = DEF_REFR_W,
    parameter int unsigned COUNT_W  = DEF_COUNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    lif_chain_if.slave bus
);

    logic [WIDTH-1:0]    v      [N_STAGES];
    logic [WIDTH-1:0]    in_val [N_STAGES];
    logic [N_STAGES-1:0] spike;
    logic [N_STAGES-1:0] fire_c;
    logic [COUNT_W-1:0]  count;
    logic                unused_sink;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        // Stage 0 is fed externally; later stages see the previous stage's registers.
        if (k == 0) begin : g_head
            assign in_val[k] = bus.i_syn;
        end else begin : g_link
            assign in_val[k] = (bus.mode == MODE_SPIKE)
                             ? (spike[k-1] ? bus.weight : '0)
                             : v[k-1];
        end

        lif_stage #(
            .WIDTH  (WIDTH),
            .REFR_W (REFR_W)
        ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (bus.en),
            .in_val      (in_val[k]),
            .threshold   (bus.threshold),
            .leak_shift  (bus.leak_shift),
            .refr_cycles (bus.refr_cycles),
            .v           (v[k]),
            .spike       (spike[k]),
            .spike_c     (fire_c[k])
        );
    end

    // Counts on the same edge the last stage's spike register goes high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            count <= '0;
        end else if (bus.clr_count) begin
            count <= '0;
        end else if (bus.en && fire_c[N_STAGES-1]) begin
            count <= COUNT_W'(sat_add(MAX_W'(count), MAX_W'(1), COUNT_W));
        end
    end

    // Only the last stage's early fire flag is needed; short chains ignore coupling inputs.
    assign unused_sink = ^{fire_c, bus.mode, bus.weight};

    assign bus.v_mem_out   = v[N_STAGES-1];
    assign bus.spikes      = spike;
    assign bus.spike_count = count;

endmodule
